// File: rtl/vmicro16_reset_ctrl.sv
// Reset controller: stretches raw reset and adds APB software reset and an optional watchdog.
// Define VMICRO16_RSTCTRL_WDT_EN to build the watchdog and its registers at word indices 2 and 3.
module vmicro16_reset_ctrl #(
  parameter int                    RST_CYCLES = 4,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] SWRST_KEY  = 16'hA5A5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            S_PADDR,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic                  S_PWRITE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  output logic                  rst_out,
  output logic [2:0]            rst_cause
);

  localparam int CW = $clog2(RST_CYCLES + 1);

  logic [CW-1:0]         cnt;
  logic                  access;
  logic                  wr;
  logic                  cause_clr;
  logic                  sw_trig;
  logic                  wdt_trig;
  logic [DATA_WIDTH-1:0] rd_load;
  logic [DATA_WIDTH-1:0] rd_cnt;

  assign access    = S_PSELx & S_PENABLE;
  assign wr        = access & S_PWRITE;
  assign cause_clr = wr && (S_PADDR == 2'd0);
  assign sw_trig   = wr && (S_PADDR == 2'd1) && (S_PWDATA == SWRST_KEY);
  assign S_PREADY  = 1'b1;

`ifdef VMICRO16_RSTCTRL_WDT_EN
  logic [DATA_WIDTH-1:0] wdt_load;
  logic [DATA_WIDTH-1:0] wdt_cnt;
  logic                  wdt_load_wr;
  logic                  wdt_kick;
  logic                  wdt_run;

  assign wdt_load_wr = wr && (S_PADDR == 2'd2);
  assign wdt_kick    = wr && (S_PADDR == 2'd3);
  // Counter is frozen while the SoC is held in reset.
  assign wdt_run     = (wdt_load != '0) && !rst_out && (wdt_cnt != '0);

  always_comb begin
    wdt_trig = 1'b0;
    if (!wdt_load_wr && !wdt_kick && wdt_run && (wdt_cnt == DATA_WIDTH'(1)))
      wdt_trig = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_load <= '0;
      wdt_cnt  <= '0;
    end else if (wdt_load_wr) begin
      wdt_load <= S_PWDATA;
      wdt_cnt  <= S_PWDATA;
    end else if (wdt_kick) begin
      wdt_cnt  <= wdt_load;
    end else if (wdt_run) begin
      wdt_cnt  <= (wdt_cnt == DATA_WIDTH'(1)) ? wdt_load : wdt_cnt - DATA_WIDTH'(1);
    end
  end

  assign rd_load = wdt_load;
  assign rd_cnt  = wdt_cnt;
`else
  assign wdt_trig = 1'b0;
  assign rd_load  = '0;
  assign rd_cnt   = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= CW'(RST_CYCLES);
      rst_out   <= 1'b1;
      rst_cause <= 3'b001;
    end else begin
      // A same-cycle clear drops old causes but keeps the new trigger's bit.
      rst_cause <= (cause_clr ? 3'b000 : rst_cause) | {wdt_trig, sw_trig, 1'b0};
      if (sw_trig || wdt_trig) begin
        cnt     <= CW'(RST_CYCLES);
        rst_out <= 1'b1;
      end else if (cnt != '0) begin
        cnt     <= cnt - CW'(1);
        rst_out <= (cnt > CW'(1));
      end
    end
  end

  always_comb begin
    S_PRDATA = '0;
    if (access) begin
      case (S_PADDR)
        2'd0:    S_PRDATA = {{(DATA_WIDTH-3){1'b0}}, rst_cause};
        2'd2:    S_PRDATA = rd_load;
        2'd3:    S_PRDATA = rd_cnt;
        default: S_PRDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_vmicro16_reset_ctrl.sv
// Bench for vmicro16_reset_ctrl: directed scenarios plus random APB traffic against a cycle-level model.
module tb_vmicro16_reset_ctrl;

  localparam int RST = 4;
  localparam logic [15:0] KEY = 16'hA5A5;
`ifdef VMICRO16_RSTCTRL_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [1:0]  S_PADDR;
  logic        S_PSELx;
  logic        S_PENABLE;
  logic        S_PWRITE;
  logic [15:0] S_PWDATA;
  logic [15:0] S_PRDATA;
  logic        S_PREADY;
  logic        rst_out;
  logic [2:0]  rst_cause;

  vmicro16_reset_ctrl #(.RST_CYCLES(RST), .DATA_WIDTH(16), .SWRST_KEY(KEY)) dut (
    .clk(clk), .reset(reset), .S_PADDR(S_PADDR), .S_PSELx(S_PSELx),
    .S_PENABLE(S_PENABLE), .S_PWRITE(S_PWRITE), .S_PWDATA(S_PWDATA),
    .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .rst_out(rst_out), .rst_cause(rst_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after a reset/trigger event at edge k, rst_out is high after edges up to k+RST-1.
  int          n         = 0;
  int          hold_until = 0;
  bit          m_valid   = 1'b0;
  logic [2:0]  m_cause   = 3'b000;
  logic [15:0] m_load    = 16'h0;
  logic [15:0] m_wcnt    = 16'h0;

  always @(posedge clk) begin : model_step
    logic wr, sw, fire, rst_now;
    n       = n + 1;
    rst_now = (n - 1) < hold_until;
    wr      = S_PSELx & S_PENABLE & S_PWRITE;
    if (reset) begin
      m_valid    = 1'b1;
      hold_until = n + RST;
      m_cause    = 3'b001;
      m_load     = 16'h0;
      m_wcnt     = 16'h0;
    end else begin
      sw   = wr && (S_PADDR == 2'd1) && (S_PWDATA == KEY);
      fire = 1'b0;
      if (WDT) begin
        if (wr && S_PADDR == 2'd2) begin
          m_load = S_PWDATA;
          m_wcnt = S_PWDATA;
        end else if (wr && S_PADDR == 2'd3) begin
          m_wcnt = m_load;
        end else if (m_load != 0 && !rst_now && m_wcnt != 0) begin
          if (m_wcnt == 1) begin
            fire   = 1'b1;
            m_wcnt = m_load;
          end else begin
            m_wcnt = m_wcnt - 16'd1;
          end
        end
      end
      if (wr && S_PADDR == 2'd0) m_cause = 3'b000;
      m_cause = m_cause | {fire, sw, 1'b0};
      if (sw || fire) hold_until = n + RST;
    end
  end

  function automatic logic [15:0] exp_rd();
    if (!(S_PSELx && S_PENABLE)) return 16'h0;
    case (S_PADDR)
      2'd0:    return {13'b0, m_cause};
      2'd2:    return WDT ? m_load : 16'h0;
      2'd3:    return WDT ? m_wcnt : 16'h0;
      default: return 16'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("rst_out", 32'(rst_out), 32'(n < hold_until));
      chk("rst_cause", 32'(rst_cause), 32'(m_cause));
      chk("prdata", 32'(S_PRDATA), 32'(exp_rd()));
      chk("pready", 32'(S_PREADY), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [15:0] d);
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b1; S_PADDR = a; S_PWDATA = d;
    tick();
    S_PENABLE = 1'b1;
    tick();
    S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [15:0] d);
    S_PSELx = 1'b1; S_PENABLE = 1'b0; S_PWRITE = 1'b0; S_PADDR = a;
    tick();
    S_PENABLE = 1'b1;
    #1 d = S_PRDATA;
    tick();
    S_PSELx = 1'b0; S_PENABLE = 1'b0;
  endtask

  // Edges (from the next one) after which rst_out is still high.
  task automatic high_run(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rst_out) cnt++;
      else break;
    end
  endtask

  initial begin : stim
    logic [15:0] d;
    int          cnt;
    bit          seen;
    reset = 1'b1; S_PADDR = 2'd0; S_PSELx = 1'b0; S_PENABLE = 1'b0;
    S_PWRITE = 1'b0; S_PWDATA = 16'h0;
    tick();
    chk("reset_rst_out", 32'(rst_out), 32'd1);
    chk("reset_cause", 32'(rst_cause), 32'd1);
    chk("reset_prdata", 32'(S_PRDATA), 32'd0);
    repeat (3) tick();
    reset = 1'b0;
    high_run(cnt);
    chk("raw_release_len", 32'(cnt), 32'(RST - 1));
    apb_read(2'd0, d);
    chk("cause_after_raw", 32'(d), 32'h1);

    apb_write(2'd1, KEY);
    chk("sw_rise", 32'(rst_out), 32'd1);
    high_run(cnt);
    chk("sw_len", 32'(cnt + 1), 32'(RST));
    apb_read(2'd0, d);
    chk("cause_after_sw", 32'(d), 32'h3);
    apb_write(2'd1, 16'h1234);
    seen = 1'b0;
    repeat (6) begin tick(); if (rst_out) seen = 1'b1; end
    chk("bad_key_no_rst", 32'(seen), 32'd0);

    apb_write(2'd1, KEY);
    apb_write(2'd1, KEY);
    chk("retrig_high", 32'(rst_out), 32'd1);
    high_run(cnt);
    chk("retrig_len", 32'(cnt + 1), 32'(RST));

    apb_write(2'd1, KEY);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    high_run(cnt);
    chk("raw_mid_seq_len", 32'(cnt), 32'(RST - 1));
    apb_read(2'd0, d);
    chk("raw_mid_cause", 32'(d), 32'h1);
    apb_write(2'd0, 16'hFFFF);
    apb_read(2'd0, d);
    chk("cause_clear", 32'(d), 32'h0);

`ifdef VMICRO16_RSTCTRL_WDT_EN
    apb_write(2'd2, 16'd10);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cnt++;
      if (rst_out) break;
    end
    chk("wdt_expire_delay", 32'(cnt), 32'd10);
    apb_read(2'd0, d);
    chk("wdt_cause", 32'(d), 32'h4);
    repeat (6) tick();
    apb_read(2'd2, d);
    chk("wdt_rearm_load", 32'(d), 32'd10);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      apb_write(2'd3, 16'h0);
      repeat (6) begin tick(); if (rst_out) seen = 1'b1; end
    end
    chk("kick_no_rst", 32'(seen), 32'd0);
    apb_write(2'd2, 16'd10);
    repeat (8) tick();
    apb_write(2'd3, 16'h0);
    seen = rst_out;
    repeat (8) begin tick(); if (rst_out) seen = 1'b1; end
    chk("kick_at_expiry", 32'(seen), 32'd0);
    apb_write(2'd2, 16'd3);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rst_out) break;
    end
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    high_run(cnt);
    chk("raw_in_wdt_len", 32'(cnt), 32'(RST - 1));
    apb_read(2'd0, d);
    chk("raw_in_wdt_cause", 32'(d), 32'h1);
    apb_read(2'd2, d);
    chk("raw_in_wdt_load", 32'(d), 32'h0);
`else
    apb_write(2'd2, 16'd5);
    apb_read(2'd2, d);
    chk("nowdt_load_reads0", 32'(d), 32'h0);
    apb_read(2'd3, d);
    chk("nowdt_cnt_reads0", 32'(d), 32'h0);
    seen = 1'b0;
    repeat (20) begin tick(); if (rst_out) seen = 1'b1; end
    chk("nowdt_no_rst", 32'(seen), 32'd0);
    chk("nowdt_cause2", 32'(rst_cause[2]), 32'd0);
`endif

    for (int it = 0; it < 1500; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        reset = 1'b1;
        repeat (int'($urandom_range(1, 3))) tick();
        reset = 1'b0;
      end else if (r < 40) begin
        repeat (int'($urandom_range(1, 4))) tick();
      end else begin
        logic [1:0]  a;
        logic [15:0] wd;
        a = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) begin
          case (a)
            2'd1:    wd = ($urandom_range(0, 2) == 0) ? KEY : 16'($urandom);
            2'd2:    wd = 16'($urandom_range(0, 24));
            2'd0:    wd = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            default: wd = 16'($urandom);
          endcase
          if (a == 2'd0 && $urandom_range(0, 3) != 0) apb_read(a, d);
          else apb_write(a, wd);
        end else begin
          apb_read(a, d);
        end
      end
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
